// File: rtl/keypad_scan_debounce.sv
// 4x4 matrix keypad scanner with press/release debounce and a ready/ack handoff.
// Optional build macro KEYPAD_REPEAT_EN adds auto-repeat while a key stays held.
module keypad_scan_debounce #(
   parameter logic [15:0] SCAN_DIV        = 16'd50000,
   parameter logic [19:0] DEBOUNCE_CYCLES = 20'd500000,
   parameter logic [25:0] REPEAT_CYCLES   = 26'd25000000
) (
   input  logic       i_clk,
   input  logic       i_rst_n,
   output logic [3:0] o_rowwrite,
   input  logic [3:0] i_colread,
   output logic [3:0] o_keyout,
   output logic       o_ready,
   input  logic       i_ack
);

   typedef enum logic [1:0] {
      S_SCAN,
      S_DEBOUNCE,
      S_HANDSHAKE,
      S_RELEASE
   } state_t;

   state_t      r_state;
   state_t      w_state_nxt;
   logic [3:0]  r_col_s1;
   logic [3:0]  r_col_s2;
   logic [1:0]  r_row;
   logic [1:0]  w_row_nxt;
   logic [15:0] r_slot;
   logic [15:0] w_slot_nxt;
   logic [19:0] r_cnt;
   logic [19:0] w_cnt_nxt;
   logic [3:0]  r_samp;
   logic [3:0]  w_samp_nxt;
   logic [3:0]  r_keyout;
   logic [3:0]  w_keyout_nxt;
   logic [3:0]  r_rowwrite;
   logic        r_ready;
   logic        w_slot_end;
   logic        w_cnt_done;
   logic        w_col_hit;

`ifdef KEYPAD_REPEAT_EN
   logic [25:0] r_rep;
   logic [25:0] w_rep_nxt;
   logic        w_rep_done;

   assign w_rep_done = (r_rep >= REPEAT_CYCLES - 26'd1);
`else
   logic        w_unused_repeat;

   assign w_unused_repeat = ^REPEAT_CYCLES;
`endif

   function automatic logic f_one_cold(input logic [3:0] col);
      case (col)
         4'b1110, 4'b1101, 4'b1011, 4'b0111: return 1'b1;
         default:                            return 1'b0;
      endcase
   endfunction

   function automatic logic [3:0] f_decode(input logic [1:0] row, input logic [3:0] col);
      case ({row, col})
         6'b00_1110: return 4'h1;
         6'b00_1101: return 4'h2;
         6'b00_1011: return 4'h3;
         6'b00_0111: return 4'hA;
         6'b01_1110: return 4'h4;
         6'b01_1101: return 4'h5;
         6'b01_1011: return 4'h6;
         6'b01_0111: return 4'hB;
         6'b10_1110: return 4'h7;
         6'b10_1101: return 4'h8;
         6'b10_1011: return 4'h9;
         6'b10_0111: return 4'hC;
         6'b11_1110: return 4'hE;
         6'b11_1101: return 4'h0;
         6'b11_1011: return 4'hF;
         6'b11_0111: return 4'hD;
         default:    return 4'h0;
      endcase
   endfunction

   assign w_slot_end = (r_slot >= SCAN_DIV - 16'd1);
   assign w_cnt_done = (r_cnt >= DEBOUNCE_CYCLES - 20'd1);
   assign w_col_hit  = (r_col_s2 == r_samp);

   // Columns come from a bouncing mechanical switch: two-flop synchronizer first.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_col_s1 <= 4'hF;
         r_col_s2 <= 4'hF;
      end else begin
         r_col_s1 <= i_colread;
         r_col_s2 <= r_col_s1;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state    <= S_SCAN;
         r_row      <= 2'd0;
         r_slot     <= 16'd0;
         r_cnt      <= 20'd0;
         r_samp     <= 4'hF;
         r_keyout   <= 4'h0;
         r_rowwrite <= 4'b1110;
         r_ready    <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
         r_rep      <= 26'd0;
`endif
      end else begin
         r_state    <= w_state_nxt;
         r_row      <= w_row_nxt;
         r_slot     <= w_slot_nxt;
         r_cnt      <= w_cnt_nxt;
         r_samp     <= w_samp_nxt;
         r_keyout   <= w_keyout_nxt;
         r_rowwrite <= ~(4'b0001 << w_row_nxt);
         r_ready    <= (w_state_nxt == S_HANDSHAKE);
`ifdef KEYPAD_REPEAT_EN
         r_rep      <= w_rep_nxt;
`endif
      end
   end

   always_comb begin
      w_state_nxt  = r_state;
      w_row_nxt    = r_row;
      w_slot_nxt   = r_slot;
      w_cnt_nxt    = r_cnt;
      w_samp_nxt   = r_samp;
      w_keyout_nxt = r_keyout;
`ifdef KEYPAD_REPEAT_EN
      w_rep_nxt    = r_rep;
`endif
      case (r_state)
         S_SCAN: begin
            if (w_slot_end) begin
               w_slot_nxt = 16'd0;
               if (f_one_cold(r_col_s2)) begin
                  w_state_nxt = S_DEBOUNCE;
                  w_samp_nxt  = r_col_s2;
                  w_cnt_nxt   = 20'd0;
               end else begin
                  w_row_nxt = r_row + 2'd1;
               end
            end else if (r_slot != 16'hFFFF) begin
               w_slot_nxt = r_slot + 16'd1;
            end
         end
         S_DEBOUNCE: begin
            if (!w_col_hit) begin
               w_state_nxt = S_SCAN;
               w_row_nxt   = r_row + 2'd1;
               w_slot_nxt  = 16'd0;
               w_cnt_nxt   = 20'd0;
            end else if (w_cnt_done) begin
               w_state_nxt  = S_HANDSHAKE;
               w_keyout_nxt = f_decode(r_row, r_samp);
               w_cnt_nxt    = 20'd0;
            end else if (r_cnt != 20'hFFFFF) begin
               w_cnt_nxt = r_cnt + 20'd1;
            end
         end
         S_HANDSHAKE: begin
            if (i_ack) begin
               w_state_nxt = S_RELEASE;
               w_cnt_nxt   = 20'd0;
`ifdef KEYPAD_REPEAT_EN
               w_rep_nxt   = 26'd0;
`endif
            end
         end
         S_RELEASE: begin
            // Row stays frozen here; only an all-high column code counts toward release.
            if (r_col_s2 == 4'hF) begin
`ifdef KEYPAD_REPEAT_EN
               w_rep_nxt = 26'd0;
`endif
               if (w_cnt_done) begin
                  w_state_nxt = S_SCAN;
                  w_row_nxt   = 2'd0;
                  w_slot_nxt  = 16'd0;
                  w_cnt_nxt   = 20'd0;
               end else if (r_cnt != 20'hFFFFF) begin
                  w_cnt_nxt = r_cnt + 20'd1;
               end
            end else begin
               w_cnt_nxt = 20'd0;
`ifdef KEYPAD_REPEAT_EN
               if (!w_col_hit) begin
                  w_rep_nxt = 26'd0;
               end else if (w_rep_done) begin
                  w_state_nxt = S_HANDSHAKE;
                  w_rep_nxt   = 26'd0;
               end else if (r_rep != 26'h3FFFFFF) begin
                  w_rep_nxt = r_rep + 26'd1;
               end
`endif
            end
         end
         default: begin
            w_state_nxt = S_SCAN;
         end
      endcase
   end

   assign o_rowwrite = r_rowwrite;
   assign o_keyout   = r_keyout;
   assign o_ready    = r_ready;

endmodule

// File: tb/tb_keypad_scan_debounce.sv
// Bench for keypad_scan_debounce: keypad matrix model, auto-acking consumer and a
// scoreboard of expected codes / latencies / ready widths popped on each ready rise.
module tb_keypad_scan_debounce;

   localparam int SDIV = 4;
   localparam int DEB  = 8;
   localparam int REP  = 40;
   localparam int LAT  = (SDIV - 1) + DEB + 1;

   typedef struct {
      logic [3:0] code;
      int         lat;
      int         wid;
   } exp_t;

   logic       clk;
   logic       rst_n;
   logic [3:0] rowwrite;
   logic [3:0] colread;
   logic [3:0] keyout;
   logic       ready;
   logic       ack;

   logic [3:0] press_mask [4];
   logic       contact;
   int         ack_dly;
   logic       extra_ok;
   logic [3:0] extra_code;

   exp_t       sb_q [$];
   int         n_checks;
   int         n_fail;
   int         cyc;
   int         rises;
   int         last_rw_cyc;

   keypad_scan_debounce #(
      .SCAN_DIV        (16'(SDIV)),
      .DEBOUNCE_CYCLES (20'(DEB)),
      .REPEAT_CYCLES   (26'(REP))
   ) dut (
      .i_clk      (clk),
      .i_rst_n    (rst_n),
      .o_rowwrite (rowwrite),
      .i_colread  (colread),
      .o_keyout   (keyout),
      .o_ready    (ready),
      .i_ack      (ack)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always_comb begin
      colread = 4'hF;
      for (int r = 0; r < 4; r++) begin
         if (!rowwrite[r] && contact) colread = colread & ~press_mask[r];
      end
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Consumer: pulse ack for one cycle, ack_dly cycles after ready is seen high.
   initial begin
      ack = 1'b0;
      forever begin
         @(negedge clk);
         if (rst_n && ready && ack_dly >= 0) begin
            repeat (ack_dly) @(negedge clk);
            ack = 1'b1;
            @(negedge clk);
            ack = 1'b0;
         end
      end
   end

   // Monitor: row-slot timing, ready rises against the scoreboard, ready width.
   initial begin
      exp_t       e;
      logic       rdy_q;
      logic [3:0] rw_q;
      int         hi_cnt;
      int         exp_wid;
      cyc = 0; rises = 0; last_rw_cyc = 0;
      rdy_q = 1'b0; rw_q = 4'b1110; hi_cnt = 0; exp_wid = -1;
      forever begin
         @(negedge clk);
         cyc++;
         if (!rst_n) begin
            rdy_q = 1'b0; rw_q = rowwrite; last_rw_cyc = cyc; hi_cnt = 0; exp_wid = -1;
         end else begin
            if (rowwrite != rw_q) begin
               last_rw_cyc = cyc;
               chk("rw_onecold", $countones(~rowwrite), 1);
            end
            rw_q = rowwrite;
            if (ready && !rdy_q) begin
               rises++;
               hi_cnt = 1;
               exp_wid = -1;
               if (sb_q.size() > 0) begin
                  e = sb_q.pop_front();
                  chk("keyout", keyout, e.code);
                  if (e.lat >= 0) chk("latency", cyc - last_rw_cyc, e.lat);
                  exp_wid = e.wid;
               end else if (extra_ok) begin
                  chk("rep_key", keyout, extra_code);
               end else begin
                  chk("unexp_ready", sb_q.size(), 1);
               end
            end else if (ready) begin
               hi_cnt++;
            end else if (rdy_q && exp_wid >= 0) begin
               chk("ready_width", hi_cnt, exp_wid);
            end
            rdy_q = ready;
         end
      end
   end

   task automatic wait_rise(input int target, input int budget);
      int n;
      n = 0;
      while (rises < target && n < budget) begin
         @(negedge clk);
         n++;
      end
      chk("wait_ready", rises, target);
   endtask

   task automatic do_press(input int r, input int c, input logic [3:0] code,
                           input int lat, input int wid, input int hold, input int dly);
      int start;
      start = rises;
      ack_dly = dly;
      sb_q.push_back('{code: code, lat: lat, wid: wid});
      press_mask[r] = 4'(1 << c);
      contact = 1'b1;
      repeat (hold) @(negedge clk);
      contact = 1'b0;
      press_mask[r] = 4'h0;
      repeat (30) @(negedge clk);
      chk("one_ready", rises - start, 1);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      int start;
      int moved;
      int n;
      logic [3:0] rw_frozen;
      n_checks = 0; n_fail = 0;
      rst_n = 1'b0; contact = 1'b0; ack_dly = 3; extra_ok = 1'b0; extra_code = 4'h0;
      for (int r = 0; r < 4; r++) press_mask[r] = 4'h0;
      repeat (3) @(negedge clk);
      chk("rst_rowwrite", rowwrite, 4'b1110);
      chk("rst_keyout", keyout, 4'h0);
      chk("rst_ready", ready, 1'b0);
      rst_n = 1'b1;
      repeat (5) @(negedge clk);

      // Clean presses with a range of keys and ack delays.
      do_press(1, 1, 4'h5, LAT, 4, 60, 3);
      do_press(3, 0, 4'hE, LAT, 4, 60, 3);
      do_press(3, 2, 4'hF, LAT, 4, 60, 3);
      do_press(3, 3, 4'hD, LAT, 1, 60, 0);
      do_press(0, 0, 4'h1, LAT, 2, 60, 1);
      do_press(2, 1, 4'h8, LAT, 4, 60, 3);

      // Press bounce: contact toggles every 3 cycles before settling.
      start = rises;
      sb_q.push_back('{code: 4'h9, lat: LAT, wid: 4});
      press_mask[2] = 4'b0100;
      for (int i = 0; i < 10; i++) begin
         contact = ~contact;
         repeat (3) @(negedge clk);
      end
      contact = 1'b1;
      repeat (60) @(negedge clk);
      contact = 1'b0;
      press_mask[2] = 4'h0;
      repeat (30) @(negedge clk);
      chk("bounce_one", rises - start, 1);

      // Release bounce: row must stay frozen until 8 clean high cycles.
      start = rises;
      sb_q.push_back('{code: 4'h6, lat: LAT, wid: 4});
      press_mask[1] = 4'b0100;
      contact = 1'b1;
      wait_rise(start + 1, 100);
      repeat (12) @(negedge clk);
      rw_frozen = rowwrite;
      chk("rb_row", rw_frozen, 4'b1101);
      moved = 0;
      for (int i = 0; i < 6; i++) begin
         contact = 1'b0;
         repeat (3) begin @(negedge clk); if (rowwrite != rw_frozen) moved++; end
         contact = 1'b1;
         repeat (3) begin @(negedge clk); if (rowwrite != rw_frozen) moved++; end
      end
      contact = 1'b0;
      n = 0;
      while (rowwrite == rw_frozen && n < 50) begin
         @(negedge clk);
         n++;
      end
      chk("rb_frozen", moved, 0);
      chk("rb_resume", n, DEB + 2);
      chk("rb_row0", rowwrite, 4'b1110);
      press_mask[1] = 4'h0;
      repeat (20) @(negedge clk);
      chk("rb_one", rises - start, 1);

      // Two columns low in row 0: not a valid key, scanning continues.
      start = rises;
      press_mask[0] = 4'b0011;
      contact = 1'b1;
      moved = 0;
      rw_frozen = rowwrite;
      repeat (60) begin
         @(negedge clk);
         if (rowwrite != rw_frozen) moved++;
         rw_frozen = rowwrite;
      end
      contact = 1'b0;
      press_mask[0] = 4'h0;
      chk("mk_noready", rises - start, 0);
      chk("mk_scan", moved >= 8, 1);
      repeat (10) @(negedge clk);

      // Reset while ready is pending: key discarded, no ready afterwards.
      ack_dly = -1;
      start = rises;
      sb_q.push_back('{code: 4'h7, lat: LAT, wid: -1});
      press_mask[2] = 4'b0001;
      contact = 1'b1;
      wait_rise(start + 1, 100);
      chk("pre_rst_ready", ready, 1'b1);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_rowwrite", rowwrite, 4'b1110);
      chk("mid_rst_ready", ready, 1'b0);
      chk("mid_rst_keyout", keyout, 4'h0);
      contact = 1'b0;
      press_mask[2] = 4'h0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      start = rises;
      repeat (60) @(negedge clk);
      chk("post_rst_noready", rises - start, 0);
      ack_dly = 3;

      // Hold "A" for 200 cycles, acking every ready.
      ack_dly = 1;
      extra_ok = 1'b1;
      extra_code = 4'hA;
      start = rises;
      sb_q.push_back('{code: 4'hA, lat: -1, wid: 2});
      press_mask[0] = 4'b1000;
      contact = 1'b1;
      repeat (200) @(negedge clk);
      contact = 1'b0;
      press_mask[0] = 4'h0;
      repeat (40) @(negedge clk);
`ifdef KEYPAD_REPEAT_EN
      chk("repeat_count", (rises - start) >= 3, 1);
`else
      chk("repeat_count", rises - start, 1);
`endif
      extra_ok = 1'b0;

      chk("sb_empty", sb_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
